// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution, one-cycle redirect and wrong-path squash.
// Optional EX_MEM_PERF_EN adds accept and redirect counters.
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [4:0]        ex_ctl,
  input  logic              ex_jump,
  input  logic [XLEN-1:0]   ex_br_target,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_result,
  output logic [XLEN-1:0]   mem_rs2,
  output logic [REG_AW-1:0] mem_rd,
  output logic [2:0]        mem_ctl,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_redirects
`endif
);

  logic              mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]   mem_result_q, mem_result_d;
  logic [XLEN-1:0]   mem_rs2_q, mem_rs2_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [2:0]        mem_ctl_q, mem_ctl_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              squash_q, squash_d;
  logic              accept, taken;

  assign ex_ready = !mem_valid_q || mem_ready;
  assign taken    = ex_jump || (ex_ctl[1] && (alu_zero ^ ex_ctl[0]));
  // A squashed op is still consumed from EX, it just never reaches MEM.
  assign accept   = ex_valid && ex_ready && !flush && !squash_q;

  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_result_d  = mem_result_q;
    mem_rs2_d     = mem_rs2_q;
    mem_rd_d      = mem_rd_q;
    mem_ctl_d     = mem_ctl_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = accept && taken;
    squash_d      = accept && taken;
    if (flush)          mem_valid_d = 1'b0;
    else if (accept)    mem_valid_d = 1'b1;
    else if (mem_ready) mem_valid_d = 1'b0;
    if (accept) begin
      mem_result_d = alu_result;
      mem_rs2_d    = ex_rs2;
      mem_rd_d     = ex_rd;
      mem_ctl_d    = ex_ctl[4:2];
      if (taken) redirect_pc_d = ex_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q   <= 1'b0;
      mem_result_q  <= '0;
      mem_rs2_q     <= '0;
      mem_rd_q      <= '0;
      mem_ctl_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_result_q  <= mem_result_d;
      mem_rs2_q     <= mem_rs2_d;
      mem_rd_q      <= mem_rd_d;
      mem_ctl_q     <= mem_ctl_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      squash_q      <= squash_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_result  = mem_result_q;
  assign mem_rs2     = mem_rs2_q;
  assign mem_rd      = mem_rd_q;
  assign mem_ctl     = mem_ctl_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  // Redirect count tracks the cause, so it lines up with the pulse one cycle later.
  always_comb begin
    perf_ops_d       = perf_ops_q + {31'd0, accept};
    perf_redirects_d = perf_redirects_q + {31'd0, redirect_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops_q       <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_ops_q       <= perf_ops_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_ops       = perf_ops_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: transaction-level reference (pending-op queue, delivery log)
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_ex_mem_stage;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst_n, ex_valid, alu_zero, ex_jump, flush, mem_ready;
  logic [XLEN-1:0] alu_result, ex_rs2, ex_br_target;
  logic [REG_AW-1:0] ex_rd;
  logic [4:0] ex_ctl;
  logic ex_ready, mem_valid, redirect;
  logic [XLEN-1:0] mem_result, mem_rs2, redirect_pc;
  logic [REG_AW-1:0] mem_rd;
  logic [2:0] mem_ctl;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_ops, perf_redirects;
`endif

  ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctl(ex_ctl), .ex_jump(ex_jump), .ex_br_target(ex_br_target), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rs2(mem_rs2), .mem_rd(mem_rd), .mem_ctl(mem_ctl),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef EX_MEM_PERF_EN
    , .perf_ops(perf_ops), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } op_t;

  int n_chk = 0, n_pass = 0, cyc = 0;

  // Reference: ops accepted but not yet consumed, redirect owed for next cycle,
  // and an in-order log of every op the MEM side actually took.
  op_t pend[$];
  logic [31:0] dlv_res[$];
  int dlv_cyc[$];
  bit m_redir, m_skip_next;
  logic [31:0] m_pc;
  logic [31:0] m_ops, m_redirs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    bit can_take, took, tk;
    op_t o;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      m_redir = 0; m_skip_next = 0; m_pc = 0; m_ops = 0; m_redirs = 0;
    end else begin
      can_take = (pend.size() == 0) || mem_ready;
      took = ex_valid && can_take && !flush && !m_skip_next;
      tk = ex_jump || (ex_ctl[1] && (alu_zero != ex_ctl[0]));
      if (pend.size() != 0 && mem_ready && !flush) begin
        dlv_res.push_back(pend[0].res);
        dlv_cyc.push_back(cyc);
      end
      if (flush || (pend.size() != 0 && mem_ready)) pend.delete();
      if (took) begin
        o.res = alu_result; o.rs2 = ex_rs2; o.rd = ex_rd; o.ctl = ex_ctl[4:2];
        pend.push_back(o);
        m_ops++;
      end
      m_redir = took && tk;
      m_skip_next = took && tk;
      if (took && tk) begin m_pc = ex_br_target; m_redirs++; end
    end
  end

  always @(negedge clk) begin
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, pend.size() != 0});
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, (pend.size() == 0) || mem_ready});
    chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
    if (pend.size() != 0) begin
      chk("mem_result", mem_result, pend[0].res);
      chk("mem_rs2", mem_rs2, pend[0].rs2);
      chk("mem_rd", {27'd0, mem_rd}, {27'd0, pend[0].rd});
      chk("mem_ctl", {29'd0, mem_ctl}, {29'd0, pend[0].ctl});
    end
    if (m_redir) chk("redirect_pc", redirect_pc, m_pc);
`ifdef EX_MEM_PERF_EN
    chk("perf_ops", perf_ops, m_ops);
    chk("perf_redirects", perf_redirects, m_redirs);
`endif
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_op(input logic v, input logic [31:0] res, input logic [4:0] ctl,
                        input logic z, input logic j, input logic [31:0] tgt);
    ex_valid = v; alu_result = res; ex_rs2 = res ^ 32'hFFFF_0000; ex_rd = res[4:0];
    ex_ctl = ctl; alu_zero = z; ex_jump = j; ex_br_target = tgt;
  endtask

  localparam logic [4:0] ALU = 5'b10000, BEQ = 5'b00010, BNE = 5'b00011, JAL = 5'b10000;

  initial begin
    logic [31:0] ops_snap;
    int n0;
    rst_n = 0; flush = 0; mem_ready = 1;
    set_op(1, 32'h77, ALU, 0, 0, 0);
    // 1 reset with ex_valid high
    tick(); tick();
    chk("rst_mem_valid", {31'd0, mem_valid}, 0);
    chk("rst_redirect", {31'd0, redirect}, 0);
    chk("rst_outputs", mem_result | mem_rs2 | {27'd0, mem_rd} | {29'd0, mem_ctl} | redirect_pc, 0);
    rst_n = 1;

    // 2 stream of four ops, no bubbles
    set_op(0, 0, ALU, 0, 0, 0); tick();
    dlv_res.delete(); dlv_cyc.delete();
    set_op(1, 32'h11, ALU, 0, 0, 0); tick();
    chk("lat1_result", mem_result, 32'h11);
    chk("lat1_rd", {27'd0, mem_rd}, 32'h11);
    set_op(1, 32'h22, ALU, 0, 0, 0); tick();
    set_op(1, 32'h33, ALU, 0, 0, 0); tick();
    set_op(1, 32'h44, ALU, 0, 0, 0); tick();
    set_op(0, 0, ALU, 0, 0, 0); tick();
    chk("stream_count", dlv_res.size(), 4);
    if (dlv_res.size() == 4) begin
      chk("stream_0", dlv_res[0], 32'h11);
      chk("stream_1", dlv_res[1], 32'h22);
      chk("stream_2", dlv_res[2], 32'h33);
      chk("stream_3", dlv_res[3], 32'h44);
      chk("stream_gap", dlv_cyc[3] - dlv_cyc[0], 3);
    end

    // 3 backpressure: 0xDEAD held three cycles, then 0xBEEF taken on release
    set_op(1, 32'hDEAD, ALU, 0, 0, 0); tick();
    mem_ready = 0;
    set_op(1, 32'hBEEF, ALU, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'd0, ex_ready}, 0);
      tick();
      chk("bp_hold", mem_result, 32'hDEAD);
      chk("bp_hold_rs2", mem_rs2, 32'hDEAD ^ 32'hFFFF_0000);
    end
    mem_ready = 1;
    #1 chk("bp_release_ready", {31'd0, ex_ready}, 1);
    tick();
    chk("bp_next", mem_result, 32'hBEEF);

    // 4 BEQ taken, following op squashed
    set_op(1, 32'h5, BEQ, 1, 0, 32'h100); tick();
    chk("beq_redirect", {31'd0, redirect}, 1);
    chk("beq_pc", redirect_pc, 32'h100);
    chk("beq_passes", mem_result, 32'h5);
    set_op(1, 32'hBAD, ALU, 0, 0, 0); tick();
    chk("beq_pulse_end", {31'd0, redirect}, 0);
    chk("squash_drop", {31'd0, mem_valid}, 0);

    // 5 BNE not taken, then JAL taken with alu_zero=0
    set_op(1, 32'h6, BNE, 1, 0, 32'h180); tick();
    chk("bne_no_redirect", {31'd0, redirect}, 0);
    chk("bne_passes", mem_result, 32'h6);
    set_op(1, 32'h7, JAL, 0, 1, 32'h200); tick();
    chk("jal_redirect", {31'd0, redirect}, 1);
    chk("jal_pc", redirect_pc, 32'h200);
    chk("jal_ctl", {29'd0, mem_ctl}, 32'h4);
    set_op(0, 0, ALU, 0, 0, 0); tick();
    chk("jal_pulse_end", {31'd0, redirect}, 0);

    // 6 flush with a taken branch and mem_ready in the same cycle
    set_op(1, 32'h66, ALU, 0, 0, 0); tick();
    ops_snap = m_ops;
    n0 = dlv_res.size();
    flush = 1;
    set_op(1, 32'h9, BEQ, 1, 0, 32'h300); tick();
    flush = 0;
    chk("flush_valid", {31'd0, mem_valid}, 0);
    chk("flush_redirect", {31'd0, redirect}, 0);
    chk("flush_no_deliver", dlv_res.size(), n0);
`ifdef EX_MEM_PERF_EN
    chk("flush_perf_ops", perf_ops, ops_snap);
`endif
    // Not squashed after a flushed branch: next op goes through
    set_op(1, 32'hA, ALU, 0, 0, 0); tick();
    chk("post_flush_accept", mem_result, 32'hA);

    // Reset mid-transfer with a jump presented: held op and redirect dropped
    mem_ready = 0;
    set_op(1, 32'hB, JAL, 0, 1, 32'h400);
    rst_n = 0; tick();
    chk("midrst_valid", {31'd0, mem_valid}, 0);
    chk("midrst_redirect", {31'd0, redirect}, 0);
    rst_n = 1; mem_ready = 1;
    set_op(0, 0, ALU, 0, 0, 0); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
